// File: rtl/pcie_activity_led_pkg.sv
// rtl/pcie_activity_led_pkg.sv - LED bit map and stretcher state type shared by pcie_activity_led.
package pcie_activity_led_pkg;

  localparam int LED_G_HB        = 0;
  localparam int LED_G_RQ        = 1;
  localparam int LED_G_RC        = 2;
  localparam int LED_G_CQ        = 3;
  localparam int LED_G_CC        = 4;

  localparam int LED_R_COR       = 0;
  localparam int LED_R_UNCOR     = 1;
  localparam int LED_R_COR_ANY   = 2;
  localparam int LED_R_UNCOR_ANY = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } stretch_state_t;

endpackage

// File: rtl/pcie_activity_led_stretch.sv
// rtl/pcie_activity_led_stretch.sv - led_stretch: retriggerable pulse stretcher, LED lit for
// STRETCH_CYCLES cycles after the most recent event.
module led_stretch #(
  parameter int STRETCH_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_event,
  output logic o_led
);
  import pcie_activity_led_pkg::*;

  localparam int             CW   = $clog2(STRETCH_CYCLES);
  localparam logic [CW-1:0]  LOAD = CW'(STRETCH_CYCLES - 1);

  stretch_state_t r_state;
  stretch_state_t w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_event) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = LOAD;
        end
      end
      ACTIVE: begin
        // LOAD = N-1 plus the final cycle at zero gives exactly N lit cycles.
        if (i_event) begin
          w_cnt_nxt = LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_led = (r_state == ACTIVE);

endmodule

// File: rtl/pcie_activity_led.sv
// rtl/pcie_activity_led.sv - PCIe activity/error LEDs, heartbeat and saturating error counters.
// PCIE_ACTIVITY_LED_ERR_LATCH_EN makes the cor/uncor error LEDs sticky until clear_counters.
module pcie_activity_led #(
  parameter int STRETCH_CYCLES   = 25000000,
  parameter int HEARTBEAT_CYCLES = 125000000,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rq_fire,
  input  logic                     rc_fire,
  input  logic                     cq_fire,
  input  logic                     cc_fire,
  input  logic                     status_error_cor,
  input  logic                     status_error_uncor,
  input  logic                     clear_counters,
  output logic [ERR_CNT_WIDTH-1:0] err_cor_count,
  output logic [ERR_CNT_WIDTH-1:0] err_uncor_count,
  output logic [7:0]               led_green,
  output logic [7:0]               led_red,
  output logic [1:0]               led_bmc,
  output logic [1:0]               led_exp
);
  import pcie_activity_led_pkg::*;

  localparam int                      HBW     = $clog2(HEARTBEAT_CYCLES);
  localparam logic [HBW-1:0]          HB_LAST = HBW'(HEARTBEAT_CYCLES - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

  logic [HBW-1:0]           r_hb_cnt;
  logic                     r_hb;
  logic [ERR_CNT_WIDTH-1:0] r_cor_cnt;
  logic [ERR_CNT_WIDTH-1:0] r_uncor_cnt;
  logic                     r_cor_any;
  logic                     r_uncor_any;
  logic [3:0]               w_fire;
  logic [3:0]               w_act_led;
  logic                     w_cor_led;
  logic                     w_uncor_led;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (r_hb_cnt == HB_LAST) begin
      r_hb_cnt <= '0;
      r_hb     <= ~r_hb;
    end else begin
      r_hb_cnt <= r_hb_cnt + HBW'(1);
    end
  end

  // A strobe coinciding with clear is counted, so the counter restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cor_cnt   <= '0;
      r_uncor_cnt <= '0;
      r_cor_any   <= 1'b0;
      r_uncor_any <= 1'b0;
    end else begin
      if (clear_counters) begin
        r_cor_cnt <= status_error_cor ? ERR_CNT_WIDTH'(1) : '0;
      end else if (status_error_cor && (r_cor_cnt != CNT_MAX)) begin
        r_cor_cnt <= r_cor_cnt + ERR_CNT_WIDTH'(1);
      end
      if (clear_counters) begin
        r_uncor_cnt <= status_error_uncor ? ERR_CNT_WIDTH'(1) : '0;
      end else if (status_error_uncor && (r_uncor_cnt != CNT_MAX)) begin
        r_uncor_cnt <= r_uncor_cnt + ERR_CNT_WIDTH'(1);
      end
      r_cor_any   <= (r_cor_cnt != '0);
      r_uncor_any <= (r_uncor_cnt != '0);
    end
  end

  assign w_fire = {cc_fire, cq_fire, rc_fire, rq_fire};

  for (genvar g = 0; g < 4; g++) begin : g_act
    led_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_stretch (
      .clk     (clk),
      .rst     (rst),
      .i_event (w_fire[g]),
      .o_led   (w_act_led[g])
    );
  end

`ifdef PCIE_ACTIVITY_LED_ERR_LATCH_EN
  logic r_cor_latch;
  logic r_uncor_latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cor_latch   <= 1'b0;
      r_uncor_latch <= 1'b0;
    end else begin
      if (status_error_cor) begin
        r_cor_latch <= 1'b1;
      end else if (clear_counters) begin
        r_cor_latch <= 1'b0;
      end
      if (status_error_uncor) begin
        r_uncor_latch <= 1'b1;
      end else if (clear_counters) begin
        r_uncor_latch <= 1'b0;
      end
    end
  end

  assign w_cor_led   = r_cor_latch;
  assign w_uncor_led = r_uncor_latch;
`else
  led_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_cor_stretch (
    .clk     (clk),
    .rst     (rst),
    .i_event (status_error_cor),
    .o_led   (w_cor_led)
  );

  led_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_uncor_stretch (
    .clk     (clk),
    .rst     (rst),
    .i_event (status_error_uncor),
    .o_led   (w_uncor_led)
  );
`endif

  always_comb begin
    led_green                  = '0;
    led_green[LED_G_HB]        = r_hb;
    led_green[LED_G_RQ]        = w_act_led[0];
    led_green[LED_G_RC]        = w_act_led[1];
    led_green[LED_G_CQ]        = w_act_led[2];
    led_green[LED_G_CC]        = w_act_led[3];
    led_red                    = '0;
    led_red[LED_R_COR]         = w_cor_led;
    led_red[LED_R_UNCOR]       = w_uncor_led;
    led_red[LED_R_COR_ANY]     = r_cor_any;
    led_red[LED_R_UNCOR_ANY]   = r_uncor_any;
  end

  assign led_bmc         = {r_uncor_any, r_hb};
  assign led_exp         = 2'b00;
  assign err_cor_count   = r_cor_cnt;
  assign err_uncor_count = r_uncor_cnt;

endmodule

// File: tb/tb_pcie_activity_led.sv
// tb/tb_pcie_activity_led.sv - scoreboard bench for pcie_activity_led (S=8, HB=16, W=4).
// Honours PCIE_ACTIVITY_LED_ERR_LATCH_EN for the error-LED scenario.
module tb_pcie_activity_led;

  logic       clk = 1'b0;
  logic       rst;
  logic       rq_fire, rc_fire, cq_fire, cc_fire;
  logic       status_error_cor, status_error_uncor, clear_counters;
  logic [3:0] err_cor_count, err_uncor_count;
  logic [7:0] led_green, led_red;
  logic [1:0] led_bmc, led_exp;
  logic [27:0] obs;

  int total = 0;
  int bad   = 0;
  logic [27:0] exp_q[$];

  always #5 clk = ~clk;

  pcie_activity_led #(
    .STRETCH_CYCLES   (8),
    .HEARTBEAT_CYCLES (16),
    .ERR_CNT_WIDTH    (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rq_fire            (rq_fire),
    .rc_fire            (rc_fire),
    .cq_fire            (cq_fire),
    .cc_fire            (cc_fire),
    .status_error_cor   (status_error_cor),
    .status_error_uncor (status_error_uncor),
    .clear_counters     (clear_counters),
    .err_cor_count      (err_cor_count),
    .err_uncor_count    (err_uncor_count),
    .led_green          (led_green),
    .led_red            (led_red),
    .led_bmc            (led_bmc),
    .led_exp            (led_exp)
  );

  assign obs = {err_cor_count, err_uncor_count, led_green, led_red, led_bmc, led_exp};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rq_fire = 0; rc_fire = 0; cq_fire = 0; cc_fire = 0;
    status_error_cor = 0; status_error_uncor = 0; clear_counters = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [27:0] e, got;
    logic hb;
    rq_fire = 1; rc_fire = 1; cq_fire = 1; cc_fire = 1;
    status_error_cor = 1; status_error_uncor = 1; clear_counters = 1;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_q.push_back(28'd0);
      @(negedge clk);
      got = obs; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_hold[%0d] got=%h want=%h", i, got, e); end
    end
    tick();
    rst = 0;
    idle_inputs();
    for (int c = 0; c < 35; c++) begin
      hb = ((c / 16) % 2) == 1;
      exp_q.push_back({4'd0, 4'd0, 7'd0, hb, 8'd0, 1'b0, hb, 2'b00});
      @(negedge clk);
      got = obs; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_hb[c=%0d] got=%h want=%h", c, got, e); end
      tick();
    end
  endtask

  task automatic test_single_rq();
    int last = -100;
    logic e, got;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      rq_fire = (c == 10);
      exp_q.push_back({27'd0, (c > last && c <= last + 8)});
      if (rq_fire) last = c;
      @(negedge clk);
      got = led_green[1]; e = exp_q.pop_front() & 28'd1; total++;
      if (got !== e) begin bad++; $display("FAIL single_rq[c=%0d] got=%b want=%b", c, got, e); end
      total++;
      if ({led_green[7:2], led_red} !== 14'd0) begin
        bad++; $display("FAIL single_rq_others[c=%0d] got=%h want=0", c, {led_green[7:2], led_red});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_retrigger();
    int last = -100;
    logic e, got;
    do_reset();
    for (int c = 0; c < 27; c++) begin
      rc_fire = (c == 10 || c == 15);
      exp_q.push_back({27'd0, (c > last && c <= last + 8)});
      if (rc_fire) last = c;
      @(negedge clk);
      got = led_green[2]; e = exp_q.pop_front() & 28'd1; total++;
      if (got !== e) begin bad++; $display("FAIL retrigger[c=%0d] got=%b want=%b", c, got, e); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    int m = 0, prev = 0;
    logic [4:0] e, got;
    do_reset();
    for (int c = 0; c < 27; c++) begin
      status_error_cor = (c < 20);
      exp_q.push_back({23'd0, (prev != 0), 4'(m)});
      prev = m;
      if (status_error_cor && m < 15) m++;
      @(negedge clk);
      got = {led_red[2], err_cor_count}; e = 5'(exp_q.pop_front()); total++;
      if (got !== e) begin bad++; $display("FAIL saturation[c=%0d] got=%h want=%h", c, got, e); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear_collision();
    int mc = 0, mu = 0, pu = 0;
    logic [9:0] e, got;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      status_error_uncor = (c < 5) || (c == 6);
      status_error_cor   = (c == 2);
      clear_counters     = (c == 6) || (c == 8);
      exp_q.push_back({18'd0, 4'(mc), 4'(mu), (pu != 0), (pu != 0)});
      pu = mu;
      if (clear_counters) begin
        mc = status_error_cor ? 1 : 0;
        mu = status_error_uncor ? 1 : 0;
      end else begin
        if (status_error_cor && mc < 15) mc++;
        if (status_error_uncor && mu < 15) mu++;
      end
      @(negedge clk);
      got = {err_cor_count, err_uncor_count, led_red[3], led_bmc[1]};
      e = 10'(exp_q.pop_front()); total++;
      if (got !== e) begin bad++; $display("FAIL clear_collision[c=%0d] got=%h want=%h", c, got, e); end
      tick();
    end
    idle_inputs();
  endtask

`ifdef PCIE_ACTIVITY_LED_ERR_LATCH_EN
  task automatic test_err_led();
    logic lc = 0, lu = 0;
    logic [1:0] e, got;
    do_reset();
    for (int c = 0; c < 116; c++) begin
      status_error_cor   = (c == 2);
      status_error_uncor = (c == 5) || (c == 110);
      clear_counters     = (c == 110);
      exp_q.push_back({26'd0, lu, lc});
      if (status_error_cor) lc = 1; else if (clear_counters) lc = 0;
      if (status_error_uncor) lu = 1; else if (clear_counters) lu = 0;
      @(negedge clk);
      got = led_red[1:0]; e = 2'(exp_q.pop_front()); total++;
      if (got !== e) begin bad++; $display("FAIL err_latch[c=%0d] got=%b want=%b", c, got, e); end
      tick();
    end
    idle_inputs();
  endtask
`else
  task automatic test_err_led();
    int lc = -100, lu = -100;
    logic [1:0] e, got;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      status_error_cor   = (c == 2);
      status_error_uncor = (c == 5);
      exp_q.push_back({26'd0, (c > lu && c <= lu + 8), (c > lc && c <= lc + 8)});
      if (status_error_cor) lc = c;
      if (status_error_uncor) lu = c;
      @(negedge clk);
      got = led_red[1:0]; e = 2'(exp_q.pop_front()); total++;
      if (got !== e) begin bad++; $display("FAIL err_stretch[c=%0d] got=%b want=%b", c, got, e); end
      tick();
    end
    idle_inputs();
  endtask
`endif

  task automatic test_mid_reset();
    logic [27:0] e, got;
    do_reset();
    rq_fire = 1; status_error_cor = 1;
    tick();
    idle_inputs();
    exp_q.push_back({4'd1, 4'd0, 8'b0000_0010, 8'b0000_0001, 2'b00, 2'b00});
    @(negedge clk);
    got = obs; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL mid_reset_pre got=%h want=%h", got, e); end
    tick();
    rst = 1; cc_fire = 1; status_error_uncor = 1;
    tick();
    exp_q.push_back(28'd0);
    @(negedge clk);
    got = obs; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL mid_reset_clear got=%h want=%h", got, e); end
    rst = 0;
    idle_inputs();
    tick();
    exp_q.push_back(28'd0);
    @(negedge clk);
    got = obs; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL mid_reset_ignored got=%h want=%h", got, e); end
    tick();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_rq();
    test_retrigger();
    test_saturation();
    test_clear_collision();
    test_err_led();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/pcie_activity_led.md
# pcie_activity_led

Status/indicator stage downstream of the DMA benchmark core on the fb2CG board. Consumes per-cycle handshake strobes from the four PCIe AXI streams (RQ, RC, CQ, CC) and the core's correctable/uncorrectable error strobes. Produces pulse-stretched activity LEDs, a heartbeat, and saturating error counters. Drives the board LED outputs that the core leaves unused.

## Interface
- STRETCH_CYCLES, 25000000: cycles an activity/error LED stays lit after its last event (≥2).
- HEARTBEAT_CYCLES, 125000000: heartbeat half-period in cycles (≥2).
- ERR_CNT_WIDTH, 16: width of each error counter.

Ports:
- clk  in  1  core clock (250 MHz); one clock only.
- rst  in  1  reset, synchronous, active-high.
- rq_fire  in  1  RQ tvalid&tready this cycle.
- rc_fire  in  1  RC tvalid&tready this cycle.
- cq_fire  in  1  CQ tvalid&tready this cycle.
- cc_fire  in  1  CC tvalid&tready this cycle.
- status_error_cor  in  1  correctable error strobe.
- status_error_uncor  in  1  uncorrectable error strobe.
- clear_counters  in  1  one-cycle request to zero both error counters.
- err_cor_count  out  ERR_CNT_WIDTH  saturating correctable error count.
- err_uncor_count  out  ERR_CNT_WIDTH  saturating uncorrectable error count.
- led_green  out  8  activity LEDs, active-high.
- led_red  out  8  error LEDs, active-high.
- led_bmc  out  2  {uncor indicator, heartbeat}.
- led_exp  out  2  tied 2'b00.

## Operation
- Bit map, led_green: [0] heartbeat, [1] RQ, [2] RC, [3] CQ, [4] CC, [7:5] 0.
- Bit map, led_red: [0] cor stretched, [1] uncor stretched, [2] err_cor_count≠0, [3] err_uncor_count≠0, [7:4] 0.
- led_bmc[1] = led_red[3]; led_bmc[0] = heartbeat.
- Stretcher (one per source, 6 total): states IDLE/ACTIVE.
  - IDLE→ACTIVE on event; counter loads STRETCH_CYCLES-1.
  - ACTIVE: event reloads counter (retrigger). Otherwise decrement; at 0 with no event go IDLE.
  - LED = (state==ACTIVE).
- Heartbeat: free-running counter 0..HEARTBEAT_CYCLES-1. Toggle heartbeat when it wraps to 0.
- Error counters: +1 per strobe cycle, saturate at all-ones (no wrap).
  - clear_counters alone → 0.
  - clear_counters with strobe same cycle → 1.
- Input strobes are level-per-cycle. A strobe held high N cycles counts N.

## Timing
- All outputs registered. Reset value of every output is 0, including heartbeat. All stretchers are IDLE and all counters 0 after reset.
- Event in cycle N → LED high from cycle N+1 through N+STRETCH_CYCLES inclusive. Low at N+STRETCH_CYCLES+1 if no further event.
- Heartbeat first rises HEARTBEAT_CYCLES cycles after rst deasserts, then toggles every HEARTBEAT_CYCLES.
- Error counter updates at N+1. led_red[2]/[3] follow one cycle after the counter (N+2).
- rst asserted mid-stretch or mid-count: all state returns to reset value next cycle. Events during rst are ignored.
- No backpressure; the block never stalls the core.

## Configuration
- PCIE_ACTIVITY_LED_ERR_LATCH_EN defined:
  - led_red[0]/[1] are sticky. They set on the first strobe and clear only on clear_counters or rst.
  - Set wins over simultaneous clear.
- Undefined: led_red[0]/[1] use the normal stretcher.

## Structure
- Shared package pcie_activity_led_pkg holds:
  - LED bit-index constants (LED_G_HB, LED_G_RQ, …, LED_R_COR, LED_R_UNCOR, LED_R_COR_ANY, LED_R_UNCOR_ANY).
  - The stretcher state typedef (IDLE/ACTIVE).
- Sub-module: led_stretch (parameter STRETCH_CYCLES; ports clk, rst, event, led), instantiated six times.

## Test plan
- Use STRETCH_CYCLES=8, HEARTBEAT_CYCLES=16, ERR_CNT_WIDTH=4 unless noted.
- Reset check: hold rst 3 cycles with all inputs high → every output 0 during and 1 cycle after reset. Heartbeat first 1 at cycle 16 after rst release.
- Single rq_fire at cycle 10 → led_green[1] high cycles 11–18, low at 19. Other LEDs unaffected.
- Retrigger: rc_fire at 10 and 15 → led_green[2] high 11–23, low at 24.
- Saturation: status_error_cor high 20 consecutive cycles → err_cor_count reaches 15 and holds. led_red[2]=1.
- Clear collision: count=5, clear_counters and status_error_uncor same cycle → err_uncor_count=1 next cycle. Clear alone → 0.
- PCIE_ACTIVITY_LED_ERR_LATCH_EN defined: one cor strobe → led_red[0] stays 1 after 100 cycles. Clears the cycle after clear_counters.
